// File: rtl/tt_response_checker.sv
// rtl/tt_response_checker.sv - truth-table response checker for 4-input combinational blocks
module tt_response_checker #(
    parameter logic [15:0] EXPECTED = 16'h6996,
    parameter int          TIMEOUT  = 400
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_vec_valid,
    input  logic        i_a,
    input  logic        i_b,
    input  logic        i_c,
    input  logic        i_d,
    input  logic        i_f,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [4:0]  o_err_count,
    output logic [15:0] o_observed,
    output logic [15:0] o_seen,
    output logic [3:0]  o_first_err_idx,
    output logic        o_first_err_vld,
    output logic        o_dup_seen,
    output logic        o_timed_out
);

    localparam logic [1:0]  S_IDLE   = 2'b00;
    localparam logic [1:0]  S_ARMED  = 2'b01;
    localparam logic [1:0]  S_DONE   = 2'b10;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [15:0] r_tcnt;
    logic [4:0]  r_err_count;
    logic [15:0] r_observed;
    logic [15:0] r_seen;
    logic [3:0]  r_first_err_idx;
    logic        r_first_err_vld;
    logic        r_dup_seen;
    logic        r_timed_out;

    logic [3:0]  w_idx;
    logic [15:0] w_onehot;
    logic        w_armed;
    logic        w_sample;
    logic        w_mismatch;
    logic        w_complete;
    logic        w_tmo_hit;

    assign w_idx      = {i_a, i_b, i_c, i_d};
    assign w_onehot   = 16'd1 << w_idx;
    assign w_armed    = (r_state == S_ARMED);
    assign w_sample   = w_armed && i_vec_valid;
    assign w_mismatch = (i_f != EXPECTED[w_idx]);
    assign w_complete = w_sample && ((r_seen | w_onehot) == 16'hFFFF);
    assign w_tmo_hit  = w_armed && (r_tcnt == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_tcnt          <= '0;
            r_err_count     <= '0;
            r_observed      <= '0;
            r_seen          <= '0;
            r_first_err_idx <= '0;
            r_first_err_vld <= 1'b0;
            r_dup_seen      <= 1'b0;
            r_timed_out     <= 1'b0;
        end else if (i_start) begin
            // start wins over any vector presented in the same cycle
            r_state         <= S_ARMED;
            r_tcnt          <= '0;
            r_err_count     <= '0;
            r_observed      <= '0;
            r_seen          <= '0;
            r_first_err_idx <= '0;
            r_first_err_vld <= 1'b0;
            r_dup_seen      <= 1'b0;
            r_timed_out     <= 1'b0;
        end else if (w_armed) begin
            r_tcnt <= r_tcnt + 16'd1;
            if (w_sample) begin
                r_observed[w_idx] <= i_f;
                r_seen[w_idx]     <= 1'b1;
                if (r_seen[w_idx]) begin
                    r_dup_seen <= 1'b1;
                end
                if (w_mismatch) begin
                    if (r_err_count != 5'd31) begin
                        r_err_count <= r_err_count + 5'd1;
                    end
                    if (!r_first_err_vld) begin
                        r_first_err_idx <= w_idx;
                        r_first_err_vld <= 1'b1;
                    end
                end
            end
            // completion takes priority over a timeout in the same cycle
            if (w_complete) begin
                r_state <= S_DONE;
            end else if (w_tmo_hit) begin
                r_state     <= S_DONE;
                r_timed_out <= 1'b1;
            end
        end
    end

    assign o_busy          = w_armed;
    assign o_done          = (r_state == S_DONE);
    assign o_pass          = o_done && (r_err_count == 5'd0) && !r_dup_seen && !r_timed_out;
    assign o_err_count     = r_err_count;
    assign o_observed      = r_observed;
    assign o_seen          = r_seen;
    assign o_first_err_idx = r_first_err_idx;
    assign o_first_err_vld = r_first_err_vld;
    assign o_dup_seen      = r_dup_seen;
    assign o_timed_out     = r_timed_out;

endmodule
